srl_seq_unit: RTL and testbench
===============================

// Module: srl_seq_unit
// PURPOSE
// - Sequential logical right shifter; the right-shift counterpart of the combinational 64-bit left-shift path.
// - Takes a 64-bit operand and a 32-bit shift amount and narrows the result to 32 bits.
// - Shifts STEP bits per cycle behind a valid/ready handshake.
// - Sits beside the left-shift unit in the ALU shift lane.
// PARAMETERS
// - DATA_W   64  operand width; the counter width is derived as $clog2(DATA_W).
// - OUT_W    32  result width; the low OUT_W bits of the shifted operand.
// - STEP     1   bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.
// PORTS
// - clock        in   1       Single clock; all state updates on its rising edge.
// - reset        in   1       Synchronous, active-high reset.
// - in_valid     in   1       Operand request valid.
// - in_ready     out  1       Unit can accept a request; high only in IDLE.
// - a            in   DATA_W  Operand to shift.
// - b            in   32      Shift amount, unsigned.
// - out_valid    out  1       Result valid; held until accepted.
// - out_ready    in   1       Consumer accepts the result.
// - result       out  OUT_W   Low OUT_W bits of (a >> b).
// - upper_nz     out  1       1 when any bit of (a >> b) at or above OUT_W is nonzero (result truncated).
// BEHAVIOUR
// - Reset (synchronous): state=IDLE, in_ready=1, out_valid=0, result=0, upper_nz=0, internal shift reg and counter=0.
//   Reset wins over every other event in the same cycle; any operation in flight is dropped with no output.
// - States and transitions:
//   - IDLE: in_valid & in_ready captures a into the shift reg and the shift amount into cnt.
//     - If b >= DATA_W: shift reg is cleared; go to DONE.
//     - Else if b == 0: go to DONE.
//     - Else: go to SHIFT.
//   - SHIFT: each cycle, shift reg >>= min(STEP, cnt) with zero fill, and cnt -= min(STEP, cnt).
//     When cnt reaches 0 on this update, go to DONE.
//   - DONE: out_valid=1; result and upper_nz come from the registered shift reg.
//     On out_ready, go to IDLE and drop out_valid the next cycle.
// - Latency from the accepting edge to out_valid high: 1 cycle if b==0 or b>=DATA_W; otherwise 1+ceil(b/STEP) cycles.
// - Handshake:
//   - in_ready = (state==IDLE). No request is accepted while a result is pending.
//   - result and upper_nz are stable while out_valid=1 && !out_ready.
//   - The earliest next accept is the cycle after out_valid & out_ready.
// - Width rules:
//   - b is unsigned 32-bit. Any nonzero bit in b[31:$clog2(DATA_W)] forces the zero result.
//   - upper_nz = |shreg[DATA_W-1:OUT_W], computed on the final value.
// - Ignored inputs: a and b are sampled only at the accept edge and ignored elsewhere. in_valid outside IDLE has no effect.
// CONFIGURATION
// - SRL_ARITH_EN defined:
//   - Adds input port `arith` (1 bit), sampled at accept.
//   - arith=1 selects an arithmetic shift: fill bits equal the captured a[DATA_W-1].
//   - With arith=1 and b>=DATA_W, the shift reg is set to all copies of a[DATA_W-1].
//   - upper_nz then flags bits above OUT_W that differ from result[OUT_W-1] (signed truncation).
// - SRL_ARITH_EN undefined: no `arith` port; zero fill only; upper_nz as defined above.
// TESTING
// - Basic shift, STEP=1: a=64'h0000_0001_0000_0000, b=4, out_ready=1.
//   -> out_valid on cycle 5 after accept; result=32'h1000_0000, upper_nz=0.
// - Zero shift: a=64'h0000_0002_DEAD_BEEF, b=0.
//   -> out_valid 1 cycle after accept; result=32'hDEAD_BEEF, upper_nz=1.
// - Oversized shift: b=64 and b=32'h8000_0000, any a.
//   -> result=0, upper_nz=0, 1-cycle latency each.
// - Backpressure: hold out_ready=0 for 10 cycles after out_valid.
//   -> result stable; in_ready=0 throughout; in_valid pulses ignored; IDLE 1 cycle after out_ready=1.
// - Reset mid-SHIFT: a=64'hFFFF_FFFF_FFFF_FFFF, b=40, assert reset 3 cycles after accept.
//   -> next cycle all outputs are reset values; a new request (a=8, b=3) returns result=1.
// - SRL_ARITH_EN: a=64'h8000_0000_0000_0000, b=63, arith=1 -> result=32'hFFFF_FFFF, upper_nz=0.
//   Same operands with arith=0 -> result=1.

Source files
------------

// File: rtl/srl_seq_unit.sv
// Sequential logical right shifter: 64-bit operand, 32-bit narrowed result, STEP bits per cycle.
// Optional arithmetic shift mode is enabled by defining SRL_ARITH_EN.
module srl_seq_unit #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned STEP   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [31:0]       b,
`ifdef SRL_ARITH_EN
    input  logic              arith,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  result,
    output logic              upper_nz
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned HI_W  = DATA_W - OUT_W;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              arith_q;
    logic              arith_c;

`ifdef SRL_ARITH_EN
    assign arith_c = arith;
`else
    assign arith_c = 1'b0;
    assign arith_q = 1'b0;
`endif

    logic              over_c;
    logic              fill_c;
    logic [CNT_W-1:0]  amt_c;
    logic [DATA_W-1:0] load_c;
    logic [DATA_W-1:0] shifted_c;

    // Signed mode flags high bits that are not a sign extension of the result.
    function automatic logic calc_nz(input logic [DATA_W-1:0] v, input logic sgn);
        if (sgn)
            return |(v[DATA_W-1:OUT_W] ^ {HI_W{v[OUT_W-1]}});
        else
            return |v[DATA_W-1:OUT_W];
    endfunction

    always_comb begin
        over_c    = |b[31:CNT_W];
        load_c    = over_c ? {DATA_W{arith_c & a[DATA_W-1]}} : a;
        amt_c     = (cnt < CNT_W'(STEP)) ? cnt : CNT_W'(STEP);
        fill_c    = arith_q & shreg[DATA_W-1];
        shifted_c = shreg >> amt_c;
        if (fill_c)
            shifted_c = shifted_c | ~({DATA_W{1'b1}} >> amt_c);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            upper_nz  <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
`ifdef SRL_ARITH_EN
            arith_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= load_c;
                        cnt      <= over_c ? '0 : b[CNT_W-1:0];
                        in_ready <= 1'b0;
`ifdef SRL_ARITH_EN
                        arith_q  <= arith_c;
`endif
                        if (over_c || b == 32'd0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= load_c[OUT_W-1:0];
                            upper_nz  <= calc_nz(load_c, arith_c);
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    shreg <= shifted_c;
                    cnt   <= cnt - amt_c;
                    if (cnt == amt_c) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= shifted_c[OUT_W-1:0];
                        upper_nz  <= calc_nz(shifted_c, arith_q);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srl_seq_unit.sv
// Self-checking bench for srl_seq_unit: directed vectors against a behavioural shift model.
// Arithmetic-mode vectors are included when SRL_ARITH_EN is defined.
module tb_srl_seq_unit;

    localparam int unsigned STEP = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [31:0] b;
    logic        arith_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        upper_nz;

    logic [31:0] exp_res;
    logic        exp_nz;
    int          total  = 0;
    int          passed = 0;

    srl_seq_unit #(.DATA_W(64), .OUT_W(32), .STEP(STEP)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
`ifdef SRL_ARITH_EN
        .arith    (arith_in),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .upper_nz (upper_nz)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Result of (a >> b) narrowed to 32 bits, plus the truncation flag.
    function automatic logic [32:0] model(input logic [63:0] av, input logic [31:0] bv, input logic ar);
        logic [63:0] full;
        logic        nz;
        full = (bv >= 32'd64) ? 64'd0 : (av >> bv);
        nz   = (full[63:32] != 32'd0);
`ifdef SRL_ARITH_EN
        if (ar) begin
            full = $signed(av) >>> ((bv >= 32'd64) ? 32'd63 : bv);
            nz   = (full[63:32] != {32{full[31]}});
        end
`endif
        if (ar === 1'bx) nz = 1'bx;
        return {nz, full[31:0]};
    endfunction

    function automatic int model_lat(input logic [31:0] bv);
        if (bv == 32'd0 || bv >= 32'd64) return 1;
        return 1 + int'((bv + STEP - 1) / STEP);
    endfunction

    // Whenever a result is presented it must match the model and block new requests.
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            check("cmp_result", 64'(result), 64'(exp_res));
            check("cmp_upper_nz", 64'(upper_nz), 64'(exp_nz));
            check("cmp_in_ready", 64'(in_ready), 64'd0);
        end
    end

    task automatic run_op(input logic [63:0] av, input logic [31:0] bv, input logic ar,
                          input int hold, input string tag,
                          output logic [31:0] got, output logic got_nz);
        int n;
        logic [31:0] held;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clock); #1; n++;
        end
        check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
        {exp_nz, exp_res} = model(av, bv, ar);
        a = av; b = bv; arith_in = ar; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = $urandom;
        arith_in = ~ar;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clock); #1; n++;
        end
        check({tag, ":latency"}, 64'(n), 64'(model_lat(bv)));
        held = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            @(posedge clock); #1;
            check({tag, ":hold_result"}, 64'(result), 64'(held));
            check({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, ":hold_out_valid"}, 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        got = result;
        got_nz = upper_nz;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check({tag, ":drop_valid"}, 64'(out_valid), 64'd0);
        check({tag, ":idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic        nz;
        logic [31:0] sweep [5];
        sweep = '{32'd1, 32'd31, 32'd32, 32'd33, 32'd63};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; arith_in = 1'b0;
        exp_res = '0; exp_nz = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_upper_nz", 64'(upper_nz), 64'd0);

        run_op(64'h0000_0001_0000_0000, 32'd4, 1'b0, 0, "basic", r, nz);
        check("basic_lit_result", 64'(r), 64'h1000_0000);
        check("basic_lit_nz", 64'(nz), 64'd0);

        run_op(64'h0000_0002_DEAD_BEEF, 32'd0, 1'b0, 0, "zero", r, nz);
        check("zero_lit_result", 64'(r), 64'hDEAD_BEEF);
        check("zero_lit_nz", 64'(nz), 64'd1);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'd64, 1'b0, 0, "over64", r, nz);
        check("over64_lit_result", 64'(r), 64'd0);
        check("over64_lit_nz", 64'(nz), 64'd0);

        run_op(64'h1234_5678_9ABC_DEF0, 32'h8000_0000, 1'b0, 0, "overmsb", r, nz);
        check("overmsb_lit_result", 64'(r), 64'd0);
        check("overmsb_lit_nz", 64'(nz), 64'd0);

        run_op(64'h0123_4567_89AB_CDEF, 32'd8, 1'b0, 10, "backpressure", r, nz);
        check("bp_lit_result", 64'(r), 64'h6789_ABCD);
        check("bp_lit_nz", 64'(nz), 64'd1);

        foreach (sweep[i])
            run_op(64'hF123_4567_89AB_CDEF, sweep[i], 1'b0, 1, "sweep", r, nz);

        // Reset lands while the long shift is still in progress.
        {exp_nz, exp_res} = model(64'hFFFF_FFFF_FFFF_FFFF, 32'd40, 1'b0);
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 32'd40; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_result", 64'(result), 64'd0);
        check("midreset_upper_nz", 64'(upper_nz), 64'd0);
        run_op(64'd8, 32'd3, 1'b0, 0, "after_reset", r, nz);
        check("after_reset_lit_result", 64'(r), 64'd1);

`ifdef SRL_ARITH_EN
        run_op(64'h8000_0000_0000_0000, 32'd63, 1'b1, 0, "arith_on", r, nz);
        check("arith_on_lit_result", 64'(r), 64'hFFFF_FFFF);
        check("arith_on_lit_nz", 64'(nz), 64'd0);
        run_op(64'h8000_0000_0000_0000, 32'd63, 1'b0, 0, "arith_off", r, nz);
        check("arith_off_lit_result", 64'(r), 64'd1);
        run_op(64'h8000_0000_0000_0000, 32'd70, 1'b1, 0, "arith_over", r, nz);
        check("arith_over_lit_result", 64'(r), 64'hFFFF_FFFF);
        run_op(64'h8765_4321_0000_0000, 32'd12, 1'b1, 2, "arith_mid", r, nz);
`endif

        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
